// File: rtl/alu_pkg.sv
// Shared ALU datapath types and constants for the sequential multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pkg;

    localparam int MUL_W    = 4;
    localparam int MUL_ITER = 4;

    // 2'd3 is never entered; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_seq4_if.sv
// Operand and product handshake bundle between the ALU and the multiplier.
// Latency: n/a (wires only).
// Backpressure: in_ready throttles operands, out_ready holds the product.
interface mul_seq4_if;
    import alu_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [MUL_W-1:0]       a;
    logic [MUL_W-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*MUL_W-1:0]     product;

    // Requester side: supplies operands, consumes the product.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/adder.sv
// 4-bit ripple adder used by the multiplier's add-and-shift step.
// Latency: combinational.
// Backpressure: none.
module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    // Carry-out is kept as the fifth result bit.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

// File: rtl/mul_seq4.sv
// Sequential 4x4 unsigned shift-add multiplier sharing one 4-bit adder.
// Latency: 4 cycles from accept to out_valid; initiation interval 6 cycles.
// Backpressure: holds DONE with a constant product until out_ready; in_ready only in IDLE.
module mul_seq4
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mul_seq4_if.slave   bus
);

    localparam logic [1:0] CNT_LAST = 2'(MUL_ITER - 1);

    mul_state_e        state_q, state_d;
    logic [MUL_W-1:0]  mcand_q, mcand_d;
    logic [MUL_W-1:0]  acc_q,   acc_d;
    logic [MUL_W-1:0]  q_q,     q_d;
    logic [1:0]        cnt_q,   cnt_d;

    logic [MUL_W-1:0]  addend;
    logic [MUL_W-1:0]  add_sum;
    logic              add_c;

    // Partial-product term: multiplicand gated by the current multiplier LSB.
    assign addend = q_q[0] ? mcand_q : '0;

    adder u_adder (
        .a    (acc_q),
        .b    (addend),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_c)
    );

    // Handshake flags decode from state alone so there is no input-to-output path.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = {acc_q, q_q};

    // Next-state and datapath: accept in IDLE, one add-and-shift per RUN cycle.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d = bus.a;
                    q_d     = bus.b;
                    acc_d   = '0;
                    cnt_d   = 2'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Carry shifts into acc MSB; sum LSB shifts into the low half.
                acc_d = {add_c, add_sum[MUL_W-1:1]};
                q_d   = {add_sum[0], q_q[MUL_W-1:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mul_seq4.sv
// Directed bench for mul_seq4: latency, products, back-pressure, reset abort, throughput.
// Latency: n/a.
// Backpressure: drives out_ready low for selected intervals.
module tb_mul_seq4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    mul_seq4_if bus ();

    mul_seq4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.in_ready && n < 20) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.in_ready), 1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // One full transaction with out_ready high; returns product and accept-to-valid latency.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output logic [7:0] p, output int lat);
        wait_ready("op_rdy");
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_valid(lat);
        p = bus.product;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] p;
        int         lat;
        int         prev_acc;
        int         acc_cyc;
        logic       seen;
        logic [3:0] b2b_a [4];
        logic [3:0] b2b_b [4];
        logic [7:0] b2b_p [4];

        b2b_a = '{4'd1, 4'd5,  4'd12,  4'd7};
        b2b_b = '{4'd1, 4'd10, 4'd12,  4'd9};
        b2b_p = '{8'd1, 8'd50, 8'd144, 8'd63};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_in_ready",  32'(bus.in_ready),  1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_product",   32'(bus.product),   0);
        rst = 1'b0;
        step();

        // 3*5: latency and return to IDLE
        run_op(4'd3, 4'd5, p, lat);
        chk("3x5_lat",  32'(lat), 4);
        chk("3x5_prod", 32'(p),   15);
        step();
        chk("3x5_idle_rdy", 32'(bus.in_ready),  1);
        chk("3x5_idle_vld", 32'(bus.out_valid), 0);

        // Carry used on every iteration
        run_op(4'd15, 4'd15, p, lat);
        chk("15x15_prod", 32'(p), 225);
        chk("15x15_lat",  32'(lat), 4);

        // Zero operands still run the full latency
        run_op(4'd0, 4'd9, p, lat);
        chk("0x9_prod", 32'(p), 0);
        chk("0x9_lat",  32'(lat), 4);
        run_op(4'd9, 4'd0, p, lat);
        chk("9x0_prod", 32'(p), 0);
        chk("9x0_lat",  32'(lat), 4);

        // Back-pressure in DONE with stray in_valid during RUN/DONE
        wait_ready("bp_rdy");
        bus.a         = 4'd6;
        bus.b         = 4'd7;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.a = 4'd1;
        bus.b = 4'd1;
        step();
        chk("bp_run_rdy", 32'(bus.in_ready), 0);
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 3);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_vld",  32'(bus.out_valid), 1);
            chk("bp_hold_prod", 32'(bus.product),   42);
            chk("bp_hold_rdy",  32'(bus.in_ready),  0);
            step();
        end
        chk("bp_after_vld",  32'(bus.out_valid), 1);
        chk("bp_after_prod", 32'(bus.product),   42);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_idle_rdy",  32'(bus.in_ready),  1);
        chk("bp_idle_vld",  32'(bus.out_valid), 0);
        chk("bp_idle_prod", 32'(bus.product),   42);

        // Reset during the second RUN cycle discards the result
        wait_ready("ab_rdy");
        bus.a         = 4'd11;
        bus.b         = 4'd13;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("ab_rst_rdy",  32'(bus.in_ready),  1);
        chk("ab_rst_vld",  32'(bus.out_valid), 0);
        chk("ab_rst_prod", 32'(bus.product),   0);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen = seen | bus.out_valid;
            step();
        end
        chk("ab_no_result", 32'(seen), 0);
        run_op(4'd2, 4'd3, p, lat);
        chk("ab_next_prod", 32'(p), 6);
        chk("ab_next_lat",  32'(lat), 4);
        step();

        // Full operand sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j), p, lat);
                chk($sformatf("sweep_%0dx%0d", i, j), 32'(p), 32'(i * j));
            end
        end
        step();

        // Back-to-back with in_valid held high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        prev_acc      = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ready("b2b_rdy");
            bus.a = b2b_a[i];
            bus.b = b2b_b[i];
            step();
            acc_cyc = cyc;
            if (i > 0) chk("b2b_gap", 32'(acc_cyc - prev_acc), 6);
            prev_acc = acc_cyc;
            wait_valid(lat);
            if (i == 3) bus.in_valid = 1'b0;
            chk("b2b_lat",  32'(lat), 4);
            chk("b2b_prod", 32'(bus.product), 32'(b2b_p[i]));
        end
        step();
        chk("b2b_end_rdy", 32'(bus.in_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
